sig_debounce: RTL
=================

SIG_DEBOUNCE -- requirements
Module: sig_debounce

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive equal synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Parameter: CNT_W, default 16, width of the qualification counter; SHALL satisfy 2**CNT_W > STABLE_CYCLES.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: sig_in  input  1  raw asynchronous level, may bounce.
REQ-006 Port: clr_cnt  input  1  synchronous clear of bounce_cnt.
REQ-007 Port: sig_out  output  1  debounced level, registered; this is the signal the downstream assertion checks with the global-clock steady/changed functions.
REQ-008 Port: rose  output  1  one-cycle pulse, registered, coincident with sig_out changing 0->1.
REQ-009 Port: fell  output  1  one-cycle pulse, registered, coincident with sig_out changing 1->0.
REQ-010 Port: steady  output  1  high when sig_out equals its value in the previous cycle; equals ~(rose|fell).
REQ-011 Port: bounce_cnt  output  8  saturating count of aborted qualifications.

Function
REQ-012 Synchronizer: two flops s1<=sig_in, s2<=s1; the FSM SHALL use only s2.
REQ-013 FSM states: LOW, QUAL_HI, HIGH, QUAL_LO; sig_out is 1 exactly in HIGH and QUAL_LO.
REQ-014 LOW: s2=1 -> QUAL_HI with cnt<=1; else stay, cnt<=0.
REQ-015 QUAL_HI: s2=0 -> LOW, cnt<=0, bounce event; s2=1 and cnt=STABLE_CYCLES-1 -> HIGH, sig_out<=1, rose<=1; else cnt<=cnt+1.
REQ-016 HIGH: s2=0 -> QUAL_LO with cnt<=1; else stay, cnt<=0.
REQ-017 QUAL_LO: s2=1 -> HIGH, cnt<=0, bounce event; s2=0 and cnt=STABLE_CYCLES-1 -> LOW, sig_out<=0, fell<=1; else cnt<=cnt+1.
REQ-018 rose and fell SHALL be high for exactly one cycle per accepted change and never simultaneously.
REQ-019 Latency: with sig_in stable from posedge P0, sig_out changes on posedge P0+STABLE_CYCLES+1.
REQ-020 Minimum spacing: two consecutive sig_out changes SHALL be at least STABLE_CYCLES cycles apart; steady therefore never low in two consecutive cycles.
REQ-021 bounce_cnt SHALL increment by 1 per bounce event and hold at 255 (no wrap).
REQ-022 clr_cnt=1 SHALL set bounce_cnt to 0 next cycle; clear wins over a simultaneous bounce event.
REQ-023 Glitches shorter than one clock may or may not be sampled; any sampled glitch shorter than STABLE_CYCLES samples SHALL produce no sig_out change.

Reset
REQ-024 rst=1 at a posedge SHALL set s1=s2=0, state=LOW, cnt=0, sig_out=0, rose=0, fell=0, bounce_cnt=0; steady=1.
REQ-025 Reset mid-qualification or in HIGH SHALL abandon it with no rose/fell pulse; if sig_in stays high, requalification starts from the first post-reset sample and REQ-019 latency applies measured from the first posedge with rst=0.
REQ-026 rst has priority over clr_cnt and all FSM transitions.

Verification (STABLE_CYCLES=4)
REQ-027 Reset, sig_in held 0 for 20 cycles -> sig_out=0, steady=1, rose=fell=0, bounce_cnt=0 throughout.
REQ-028 sig_in 0->1 sampled at posedge P0, held -> sig_out=1 and rose=1 at P0+5 only; steady=0 at P0+5, 1 otherwise.
REQ-029 While LOW, sig_in high for 2 cycles then low -> sig_out stays 0, bounce_cnt=1; repeat 300 times -> bounce_cnt=255.
REQ-030 In HIGH, sig_in low 3 cycles, high 1, low held -> bounce_cnt+1, then fell=1 exactly 5 cycles after the final low sample.
REQ-031 rst asserted in QUAL_HI with cnt=3, sig_in held 1 -> no rose at the would-be edge; sig_out=1 at 5 posedges after rst deasserts.
REQ-032 clr_cnt=1 in the same cycle as a bounce event with bounce_cnt=7 -> bounce_cnt=0 next cycle.

Source files
------------

// File: rtl/sig_debounce.sv
// Level debouncer: two-flop synchronizer followed by a qualification FSM.
// Emits registered edge pulses and a saturating count of aborted qualifications.
module sig_debounce #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    input  logic       clr_cnt,
    output logic       sig_out,
    output logic       rose,
    output logic       fell,
    output logic       steady,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             out_n;
    logic             rose_n;
    logic             fell_n;
    logic             bounce;
    logic [7:0]       bcnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            state      <= LOW;
            cnt        <= '0;
            sig_out    <= 1'b0;
            rose       <= 1'b0;
            fell       <= 1'b0;
            bounce_cnt <= 8'd0;
        end else begin
            s1         <= sig_in;
            s2         <= s1;
            state      <= state_n;
            cnt        <= cnt_n;
            sig_out    <= out_n;
            rose       <= rose_n;
            fell       <= fell_n;
            bounce_cnt <= bcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = sig_out;
        rose_n  = 1'b0;
        fell_n  = 1'b0;
        bounce  = 1'b0;
        unique case (state)
            LOW: begin
                if (s2) begin
                    state_n = QUAL_HI;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = '0;
                end
            end
            QUAL_HI: begin
                if (!s2) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    bounce  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    out_n   = 1'b1;
                    rose_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_n = QUAL_LO;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = '0;
                end
            end
            QUAL_LO: begin
                if (s2) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                    bounce  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    out_n   = 1'b0;
                    fell_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = LOW;
                cnt_n   = '0;
                out_n   = 1'b0;
            end
        endcase
    end

    // Clear takes precedence over a coincident bounce event.
    always_comb begin
        bcnt_n = bounce_cnt;
        if (clr_cnt) begin
            bcnt_n = 8'd0;
        end else if (bounce && bounce_cnt != 8'd255) begin
            bcnt_n = bounce_cnt + 8'd1;
        end
    end

    assign steady = ~(rose | fell);

endmodule
